// File: rtl/daq_pkg.sv
// ---------------------------------------------------------------------------
// daq_pkg
//  Shared definitions for the DAQ frame builder and the xillydemo top level:
//  run-control command codes, default frame marker words, the frame builder
//  state encoding and the decoded command-level bundle.
// ---------------------------------------------------------------------------
package daq_pkg;

  // Run-control command bytes written by the host into demoarray[0].
  localparam logic [7:0] CMD_START = 8'hFF;
  localparam logic [7:0] CMD_RESET = 8'hC0;
  localparam logic [7:0] CMD_CLOSE = 8'hC7;

  // Default frame layout.
  localparam int          DAQ_PAYLOAD_WORDS = 24;
  localparam logic [31:0] DAQ_HEAD_WORD     = 32'hAAAA_AAAA;
  localparam logic [31:0] DAQ_TAIL_WORD     = 32'hF0F0_F0F0;

  // Frame builder states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TAIL    = 2'd3
  } daq_state_e;

  // Decoded command levels. 'close' covers every value that is neither
  // START nor RESET, so an unknown byte lets the current frame finish.
  typedef struct packed {
    logic start;
    logic reset;
    logic close;
  } cmd_lvl_t;

  function automatic cmd_lvl_t decode_cmd(input logic [7:0] cmd);
    cmd_lvl_t lvl;
    lvl.start = (cmd == CMD_START);
    lvl.reset = (cmd == CMD_RESET);
    lvl.close = !lvl.start && !lvl.reset;
    return lvl;
  endfunction

  // Payload word layout: earlier sample in the upper half.
  function automatic logic [31:0] pack_word(input logic [15:0] first_sample,
                                            input logic [15:0] second_sample);
    return {first_sample, second_sample};
  endfunction

endpackage

// File: rtl/daq_cmd_decode.sv
// ---------------------------------------------------------------------------
// daq_cmd_decode
//  Turns the raw command byte into registered start/reset/close levels so
//  the frame builder FSM sees clean single-bit flags from a flop.
// Ports
//  bus_clk  in   clock
//  reset_n  in   asynchronous active-low reset
//  cfg_cmd  in   command byte (demoarray[0])
//  lvl      out  registered command levels
// ---------------------------------------------------------------------------
module daq_cmd_decode
  import daq_pkg::*;
(
  input  logic       bus_clk,
  input  logic       reset_n,
  input  logic [7:0] cfg_cmd,
  output cmd_lvl_t   lvl
);

  cmd_lvl_t lvl_d;
  cmd_lvl_t lvl_q;

  always_comb begin
    lvl_d = decode_cmd(cfg_cmd);
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/daq_frame_builder.sv
// ---------------------------------------------------------------------------
// daq_frame_builder
//  Packs a 16-bit sample stream into 32-bit words and wraps each group of
//  PAYLOAD_WORDS words with a HEAD and TAIL marker, writing the result into
//  the read FIFO behind /dev/xillybus_read_32.
// Ports
//  bus_clk       in   clock
//  reset_n       in   asynchronous active-low reset
//  cfg_cmd       in   run-control command byte
//  sample_data   in   16-bit sample
//  sample_valid  in   sample_data valid
//  sample_ready  out  sample accepted when valid && ready
//  fifo_full     in   FIFO prog_full
//  fifo_din      out  FIFO write data (registered)
//  fifo_wr_en    out  FIFO write strobe (registered)
//  fifo_srst     out  FIFO synchronous reset (registered)
//  running       out  frame in progress (registered)
//  frame_count   out  completed frames, wrapping (registered)
//  overflow      out  sticky: sample offered while FIFO full (registered)
// ---------------------------------------------------------------------------
module daq_frame_builder
  import daq_pkg::*;
#(
  parameter int          PAYLOAD_WORDS = DAQ_PAYLOAD_WORDS,
  parameter logic [31:0] HEAD_WORD     = DAQ_HEAD_WORD,
  parameter logic [31:0] TAIL_WORD     = DAQ_TAIL_WORD
) (
  input  logic        bus_clk,
  input  logic        reset_n,
  input  logic [7:0]  cfg_cmd,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        fifo_full,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        fifo_srst,
  output logic        running,
  output logic [15:0] frame_count,
  output logic        overflow
);

  localparam int CNT_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PAYLOAD_WORDS - 1);

  cmd_lvl_t cmd_lvl;

  daq_cmd_decode u_cmd_decode (
    .bus_clk (bus_clk),
    .reset_n (reset_n),
    .cfg_cmd (cfg_cmd),
    .lvl     (cmd_lvl)
  );

  daq_state_e       state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]      hi_q, hi_d;
  logic             hi_valid_q, hi_valid_d;
  logic [31:0]      din_q, din_d;
  logic             wr_en_q, wr_en_d;
  logic             srst_q, srst_d;
  logic             running_q, running_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             overflow_q, overflow_d;
  logic             accept;

  // A pending abort blocks acceptance so no sample is taken into a frame
  // that is about to be thrown away.
  assign sample_ready = (state_q == ST_PAYLOAD) && !fifo_full && !cmd_lvl.reset;
  assign accept       = sample_valid && sample_ready;

  // Next-state and output logic. The abort branch sits outside the state
  // case so it overrides everything, including a TAIL write in the same
  // cycle. HEAD/TAIL simply wait in their state while the FIFO is full, and
  // payload words are only formed on an accepted sample (which already
  // requires !fifo_full), so nothing is ever dropped.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    hi_d          = hi_q;
    hi_valid_d    = hi_valid_q;
    din_d         = din_q;
    wr_en_d       = 1'b0;
    srst_d        = 1'b0;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q | (running_q && sample_valid && fifo_full);

    if (cmd_lvl.reset) begin
      state_d       = ST_IDLE;
      word_cnt_d    = '0;
      hi_d          = '0;
      hi_valid_d    = 1'b0;
      srst_d        = 1'b1;
      frame_count_d = '0;
      overflow_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_lvl.start) begin
            state_d = ST_HEAD;
          end
        end

        ST_HEAD: begin
          word_cnt_d = '0;
          hi_valid_d = 1'b0;
          if (!fifo_full) begin
            din_d   = HEAD_WORD;
            wr_en_d = 1'b1;
            state_d = ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (accept) begin
            if (!hi_valid_q) begin
              hi_d       = sample_data;
              hi_valid_d = 1'b1;
            end else begin
              hi_valid_d = 1'b0;
              din_d      = pack_word(hi_q, sample_data);
              wr_en_d    = 1'b1;
              if (word_cnt_q == LAST_WORD) begin
                word_cnt_d = '0;
                state_d    = ST_TAIL;
              end else begin
                word_cnt_d = word_cnt_q + 1'b1;
              end
            end
          end
        end

        ST_TAIL: begin
          if (!fifo_full) begin
            din_d         = TAIL_WORD;
            wr_en_d       = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = (cmd_lvl.start && !cmd_lvl.close) ? ST_HEAD : ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // running tracks the state register exactly, one flop later than the
    // decision, just like every other registered output.
    running_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      hi_q          <= '0;
      hi_valid_q    <= 1'b0;
      din_q         <= '0;
      wr_en_q       <= 1'b0;
      srst_q        <= 1'b0;
      running_q     <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      hi_q          <= hi_d;
      hi_valid_q    <= hi_valid_d;
      din_q         <= din_d;
      wr_en_q       <= wr_en_d;
      srst_q        <= srst_d;
      running_q     <= running_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign fifo_din    = din_q;
  assign fifo_wr_en  = wr_en_q;
  assign fifo_srst   = srst_q;
  assign running     = running_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;

endmodule
